// File: rtl/wb_pkg.sv
// Shared types and default sizes for the write-back stage.
package wb_pkg;
  localparam int DATA_W_DEF  = 32;
  localparam int ADDR_W_DEF  = 4;
  localparam int TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } wb_state_t;
endpackage

// File: rtl/wb_stage_if.sv
// Bundle of the MEM-side, memory-side and register-file-side signals of wb_stage.
// Optional WB_FWD_EN adds the in-flight-load hazard outputs.
interface wb_stage_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    import wb_pkg::*;

    // valid/ready: a transfer happens on a posedge where both are 1; the
    // producer holds valid and payload stable until that edge.
    logic              in_valid;
    logic              in_ready;
    logic              in_wb_en;
    logic              in_mem_r_en;
    logic [ADDR_W-1:0] in_dest;
    logic [DATA_W-1:0] in_alu_result;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [DATA_W-1:0] mem_req_addr;
    logic              mem_rsp_valid;
    logic [DATA_W-1:0] mem_rsp_data;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_dest;
    logic [DATA_W-1:0] wb_value;
    logic              err;
    wb_state_t         dbg_state;
`ifdef WB_FWD_EN
    logic              fwd_pend;
    logic [ADDR_W-1:0] fwd_pend_dest;
`endif

    modport master (
        output in_valid, in_wb_en, in_mem_r_en, in_dest, in_alu_result,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  in_ready, mem_req_valid, mem_req_addr,
        input  wb_en, wb_dest, wb_value, err, dbg_state
`ifdef WB_FWD_EN
        , input fwd_pend, fwd_pend_dest
`endif
    );

    modport slave (
        input  in_valid, in_wb_en, in_mem_r_en, in_dest, in_alu_result,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output in_ready, mem_req_valid, mem_req_addr,
        output wb_en, wb_dest, wb_value, err, dbg_state
`ifdef WB_FWD_EN
        , output fwd_pend, fwd_pend_dest
`endif
    );
endinterface

// File: rtl/wb_timeout_cnt.sv
// Clear/enable cycle counter that saturates at TIMEOUT-1 and flags it.
module wb_timeout_cnt #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] cnt;

    assign tc = (cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !tc) begin
            cnt <= cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/wb_stage.sv
// Write-back stage: retires ALU results directly and completes loads over mem req/rsp.
// Define WB_FWD_EN to export the pending-load destination for the hazard unit.
module wb_stage
    import wb_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input logic        clk,
    input logic        rst,
    wb_stage_if.slave  bus
);
    wb_state_t         state;
    logic [ADDR_W-1:0] lat_dest;
    logic              lat_wb;
    logic              tc;
    logic              rsp_take;

    wb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (state != WAIT),
        .en  (state == WAIT),
        .tc  (tc)
    );

    // A response is taken in WAIT, or in REQ on the very edge the request is accepted.
    assign rsp_take = bus.mem_rsp_valid &&
                      ((state == WAIT) || (state == REQ && bus.mem_req_ready));

    assign bus.in_ready  = (state == IDLE);
    assign bus.dbg_state = state;
`ifdef WB_FWD_EN
    assign bus.fwd_pend_dest = lat_dest;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            lat_dest         <= '0;
            lat_wb           <= 1'b0;
            bus.mem_req_valid <= 1'b0;
            bus.mem_req_addr <= '0;
            bus.wb_en        <= 1'b0;
            bus.wb_dest      <= '0;
            bus.wb_value     <= '0;
            bus.err          <= 1'b0;
`ifdef WB_FWD_EN
            bus.fwd_pend     <= 1'b0;
`endif
        end else begin
            bus.wb_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (bus.in_mem_r_en) begin
                            lat_dest          <= bus.in_dest;
                            lat_wb            <= bus.in_wb_en;
                            bus.mem_req_valid <= 1'b1;
                            bus.mem_req_addr  <= bus.in_alu_result;
                            state             <= REQ;
`ifdef WB_FWD_EN
                            bus.fwd_pend      <= bus.in_wb_en;
`endif
                        end else if (bus.in_wb_en) begin
                            bus.wb_en    <= 1'b1;
                            bus.wb_dest  <= bus.in_dest;
                            bus.wb_value <= bus.in_alu_result;
                        end
                    end
                end
                REQ: begin
                    if (bus.mem_req_ready) begin
                        bus.mem_req_valid <= 1'b0;
                        state             <= WAIT;
                    end
                end
                WAIT: begin
                    if (tc && !bus.mem_rsp_valid) begin
                        bus.err <= 1'b1;
                        state   <= IDLE;
`ifdef WB_FWD_EN
                        bus.fwd_pend <= 1'b0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase

            // Completion overrides the REQ->WAIT move when req and rsp coincide.
            if (rsp_take) begin
                state <= IDLE;
                if (lat_wb) begin
                    bus.wb_en    <= 1'b1;
                    bus.wb_dest  <= lat_dest;
                    bus.wb_value <= bus.mem_rsp_data;
                end
`ifdef WB_FWD_EN
                bus.fwd_pend <= 1'b0;
`endif
            end
        end
    end
endmodule
